mold_ab_arbiter: RTL and testbench

MOLD_AB_ARBITER -- requirements
Module: mold_ab_arbiter

---
 rtl/mold_ab_arbiter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mold_ab_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mold_ab_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mold_ab_arbiter
// Purpose  : A/B UDP feed arbiter ahead of the MoldUDP64 parser. It forwards
//            the first copy of each sequence range and drops stale copies.
// Options  : MOLD_AB_GAP_DETECT_EN adds the gap_v_o / gap_len_o outputs.
// Revision : 1.0  initial release
// ============================================================================
module mold_ab_arbiter #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  a_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] a_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] a_axis_tdata_i,
  input  logic                  a_axis_tlast_i,
  input  logic                  a_axis_tuser_i,
  output logic                  a_axis_tready_o,

  input  logic                  b_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] b_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] b_axis_tdata_i,
  input  logic                  b_axis_tlast_i,
  input  logic                  b_axis_tuser_i,
  output logic                  b_axis_tready_o,

  output logic                  m_axis_tvalid_o,
  output logic [AXI_KEEP_W-1:0] m_axis_tkeep_o,
  output logic [AXI_DATA_W-1:0] m_axis_tdata_o,
  output logic                  m_axis_tlast_o,
  output logic                  m_axis_tuser_o,
  input  logic                  m_axis_tready_i,

  output logic [63:0]           exp_seq_o,
  output logic [15:0]           drop_cnt_o
`ifdef MOLD_AB_GAP_DETECT_EN
  ,
  output logic                  gap_v_o,
  output logic [63:0]           gap_len_o
`endif
);

  typedef enum logic [1:0] {
    CAP0 = 2'd0,
    CAP1 = 2'd1,
    HOLD = 2'd2
  } cap_state_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REPLAY0 = 3'd1,
    REPLAY1 = 3'd2,
    STREAM  = 3'd3,
    DROP    = 3'd4
  } out_state_e;

  // Index 0 is feed A, index 1 is feed B.
  logic [1:0]            in_vld;
  logic [1:0]            in_last;
  logic [1:0]            in_user;
  logic [AXI_DATA_W-1:0] in_data [2];
  logic [AXI_KEEP_W-1:0] in_keep [2];

  assign in_vld     = {b_axis_tvalid_i, a_axis_tvalid_i};
  assign in_last    = {b_axis_tlast_i,  a_axis_tlast_i};
  assign in_user    = {b_axis_tuser_i,  a_axis_tuser_i};
  assign in_data[0] = a_axis_tdata_i;
  assign in_data[1] = b_axis_tdata_i;
  assign in_keep[0] = a_axis_tkeep_i;
  assign in_keep[1] = b_axis_tkeep_i;

  cap_state_e            cap_q [2];
  cap_state_e            cap_d [2];
  logic [AXI_DATA_W-1:0] beat0_q [2];
  logic [AXI_DATA_W-1:0] beat1_q [2];

  out_state_e            out_q, out_d;
  logic                  sel_q, sel_d;
  logic [63:0]           exp_seq_q, exp_seq_d;
  logic                  exp_vld_q, exp_vld_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic [1:0]            early_drop;
  logic [1:0]            hold_done;
  logic [1:0]            tready;
  logic                  dec_drop;

  logic                  m_vld, m_last, m_user;
  logic [AXI_DATA_W-1:0] m_data;
  logic [AXI_KEEP_W-1:0] m_keep;

  // A wins when both feeds sit in HOLD; B waits for the next IDLE cycle.
  logic        dec_req, dec_sel, dec_fwd;
  logic [63:0] dec_seq, dec_next;
  logic [15:0] dec_cnt;

  assign dec_sel  = ~((cap_q[0] == HOLD) && in_vld[0]);
  assign dec_req  = ((cap_q[0] == HOLD) && in_vld[0]) || ((cap_q[1] == HOLD) && in_vld[1]);
  assign dec_seq  = {in_data[dec_sel][15:0], beat1_q[dec_sel][63:16]};
  assign dec_cnt  = in_data[dec_sel][31:16];
  assign dec_next = dec_seq + ((dec_cnt == 16'hFFFF) ? 64'd0 : {48'd0, dec_cnt});
  assign dec_fwd  = !exp_vld_q || (dec_seq >= exp_seq_q);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cap_d[i]      = cap_q[i];
      early_drop[i] = 1'b0;
      case (cap_q[i])
        CAP0: begin
          if (in_vld[i]) begin
            if (in_last[i]) early_drop[i] = 1'b1;
            else            cap_d[i]      = CAP1;
          end
        end
        CAP1: begin
          if (in_vld[i]) begin
            early_drop[i] = in_last[i];
            cap_d[i]      = in_last[i] ? CAP0 : HOLD;
          end
        end
        HOLD: begin
          if (hold_done[i]) cap_d[i] = CAP0;
        end
        default: cap_d[i] = CAP0;
      endcase
    end
  end

  always_comb begin
    out_d     = out_q;
    sel_d     = sel_q;
    exp_seq_d = exp_seq_q;
    exp_vld_d = exp_vld_q;
    dec_drop  = 1'b0;
    hold_done = 2'b00;
    tready[0] = (cap_q[0] != HOLD);
    tready[1] = (cap_q[1] != HOLD);
    m_vld     = 1'b0;
    m_data    = '0;
    m_keep    = '0;
    m_last    = 1'b0;
    m_user    = 1'b0;
    case (out_q)
      IDLE: begin
        if (dec_req) begin
          sel_d = dec_sel;
          if (dec_fwd) begin
            out_d     = REPLAY0;
            exp_seq_d = dec_next;
            exp_vld_d = 1'b1;
          end else begin
            out_d    = DROP;
            dec_drop = 1'b1;
          end
        end
      end
      REPLAY0: begin
        m_vld  = 1'b1;
        m_data = beat0_q[sel_q];
        m_keep = '1;
        if (m_axis_tready_i) out_d = REPLAY1;
      end
      REPLAY1: begin
        m_vld  = 1'b1;
        m_data = beat1_q[sel_q];
        m_keep = '1;
        if (m_axis_tready_i) out_d = STREAM;
      end
      STREAM: begin
        m_vld         = in_vld[sel_q];
        m_data        = in_data[sel_q];
        m_keep        = in_keep[sel_q];
        m_last        = in_last[sel_q];
        m_user        = in_user[sel_q];
        tready[sel_q] = m_axis_tready_i;
        if (in_vld[sel_q] && m_axis_tready_i && in_last[sel_q]) begin
          hold_done[sel_q] = 1'b1;
          out_d            = IDLE;
        end
      end
      DROP: begin
        tready[sel_q] = 1'b1;
        if (in_vld[sel_q] && in_last[sel_q]) begin
          hold_done[sel_q] = 1'b1;
          out_d            = IDLE;
        end
      end
      default: out_d = IDLE;
    endcase
  end

  // Up to three drops can land in one cycle (two early tlasts plus a decision).
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign drop_inc   = {1'b0, early_drop[0]} + {1'b0, early_drop[1]} + {1'b0, dec_drop};
  assign drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
  assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q[0]   <= CAP0;
      cap_q[1]   <= CAP0;
      out_q      <= IDLE;
      sel_q      <= 1'b0;
      exp_seq_q  <= 64'd0;
      exp_vld_q  <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      cap_q[0]   <= cap_d[0];
      cap_q[1]   <= cap_d[1];
      out_q      <= out_d;
      sel_q      <= sel_d;
      exp_seq_q  <= exp_seq_d;
      exp_vld_q  <= exp_vld_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if ((cap_q[i] == CAP0) && in_vld[i]) beat0_q[i] <= in_data[i];
      if ((cap_q[i] == CAP1) && in_vld[i]) beat1_q[i] <= in_data[i];
    end
  end

`ifdef MOLD_AB_GAP_DETECT_EN
  logic        gap_hit;
  logic        gap_v_q;
  logic [63:0] gap_len_q;

  assign gap_hit = (out_q == IDLE) && dec_req && dec_fwd && exp_vld_q && (dec_seq > exp_seq_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_v_q   <= 1'b0;
      gap_len_q <= 64'd0;
    end else begin
      gap_v_q <= gap_hit;
      if (gap_hit) gap_len_q <= dec_seq - exp_seq_q;
    end
  end

  assign gap_v_o   = gap_v_q;
  assign gap_len_o = gap_len_q;
`endif

  // Reset gates tready combinationally since CAP0 would otherwise show ready.
  assign a_axis_tready_o = tready[0] & ~reset;
  assign b_axis_tready_o = tready[1] & ~reset;
  assign m_axis_tvalid_o = m_vld;
  assign m_axis_tdata_o  = m_data;
  assign m_axis_tkeep_o  = m_keep;
  assign m_axis_tlast_o  = m_last;
  assign m_axis_tuser_o  = m_user;
  assign exp_seq_o       = exp_seq_q;
  assign drop_cnt_o      = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mold_ab_arbiter.sv
`default_nettype none
// Testbench for mold_ab_arbiter: directed and random packets checked against a
// packet-level reference model of the forward/drop rules.
module tb_mold_ab_arbiter;
  localparam int DW = 64;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_axis_tvalid_i, a_axis_tlast_i, a_axis_tuser_i, a_axis_tready_o;
  logic [KW-1:0] a_axis_tkeep_i;
  logic [DW-1:0] a_axis_tdata_i;
  logic          b_axis_tvalid_i, b_axis_tlast_i, b_axis_tuser_i, b_axis_tready_o;
  logic [KW-1:0] b_axis_tkeep_i;
  logic [DW-1:0] b_axis_tdata_i;
  logic          m_axis_tvalid_o, m_axis_tlast_o, m_axis_tuser_o, m_axis_tready_i;
  logic [KW-1:0] m_axis_tkeep_o;
  logic [DW-1:0] m_axis_tdata_o;
  logic [63:0]   exp_seq_o;
  logic [15:0]   drop_cnt_o;
`ifdef MOLD_AB_GAP_DETECT_EN
  logic          gap_v_o;
  logic [63:0]   gap_len_o;
`endif

  always #5 clk = ~clk;

  mold_ab_arbiter #(.AXI_DATA_W(DW), .AXI_KEEP_W(KW)) dut (
    .clk(clk), .reset(reset),
    .a_axis_tvalid_i(a_axis_tvalid_i), .a_axis_tkeep_i(a_axis_tkeep_i),
    .a_axis_tdata_i(a_axis_tdata_i), .a_axis_tlast_i(a_axis_tlast_i),
    .a_axis_tuser_i(a_axis_tuser_i), .a_axis_tready_o(a_axis_tready_o),
    .b_axis_tvalid_i(b_axis_tvalid_i), .b_axis_tkeep_i(b_axis_tkeep_i),
    .b_axis_tdata_i(b_axis_tdata_i), .b_axis_tlast_i(b_axis_tlast_i),
    .b_axis_tuser_i(b_axis_tuser_i), .b_axis_tready_o(b_axis_tready_o),
    .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tkeep_o(m_axis_tkeep_o),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tlast_o(m_axis_tlast_o),
    .m_axis_tuser_o(m_axis_tuser_o), .m_axis_tready_i(m_axis_tready_i),
    .exp_seq_o(exp_seq_o), .drop_cnt_o(drop_cnt_o)
`ifdef MOLD_AB_GAP_DETECT_EN
    , .gap_v_o(gap_v_o), .gap_len_o(gap_len_o)
`endif
  );

  // Beat = {tlast, tuser, tkeep, tdata}
  typedef logic [73:0] beat_t;
  beat_t a_q[$], b_q[$], out_q[$], exp_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          first_out_cyc = -1;
  bit          gaps_en  = 1'b0;
  int          rdy_mode = 1;
  logic [63:0] m_exp_seq = 64'd0;
  bit          m_exp_vld = 1'b0;
  int          m_drop    = 0;
  int          gap_seen  = 0;
  int          exp_gap_n = 0;
  logic [63:0] gap_last    = 64'd0;
  logic [63:0] exp_gap_len = 64'd0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_drop();
    if (m_drop < 65535) m_drop++;
  endtask

  // Builds a packet on one feed and applies the forward/drop rules to it.
  task automatic make_pkt(input bit port, input logic [63:0] seq, input logic [15:0] cnt, input int len);
    beat_t       pkt[$];
    beat_t       bt;
    logic [63:0] d;
    logic [7:0]  k;
    logic        u;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      k = 8'($urandom);
      u = 1'($urandom);
      if (i == 1) d[63:16] = seq[47:0];
      if (i == 2) d[31:0]  = {cnt, seq[63:48]};
      pkt.push_back({(i == len - 1), u, k, d});
    end
    foreach (pkt[i]) begin
      if (port) b_q.push_back(pkt[i]);
      else      a_q.push_back(pkt[i]);
    end
    if (len < 3) begin
      model_drop();
    end else if (!m_exp_vld || seq >= m_exp_seq) begin
      if (m_exp_vld && seq > m_exp_seq) begin
        exp_gap_n++;
        exp_gap_len = seq - m_exp_seq;
      end
      foreach (pkt[i]) begin
        bt = pkt[i];
        if (i < 2) begin
          bt[73]    = 1'b0;
          bt[72]    = 1'b0;
          bt[71:64] = 8'hFF;
        end
        exp_q.push_back(bt);
      end
      m_exp_seq = seq + ((cnt == 16'hFFFF) ? 64'd0 : {48'd0, cnt});
      m_exp_vld = 1'b1;
    end else begin
      model_drop();
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (a_q.size() > 0 && (!gaps_en || $urandom_range(3) != 0)) begin
      a_axis_tvalid_i = 1'b1;
      {a_axis_tlast_i, a_axis_tuser_i, a_axis_tkeep_i, a_axis_tdata_i} = a_q[0];
    end else a_axis_tvalid_i = 1'b0;
    if (b_q.size() > 0 && (!gaps_en || $urandom_range(3) != 0)) begin
      b_axis_tvalid_i = 1'b1;
      {b_axis_tlast_i, b_axis_tuser_i, b_axis_tkeep_i, b_axis_tdata_i} = b_q[0];
    end else b_axis_tvalid_i = 1'b0;
    case (rdy_mode)
      0:       m_axis_tready_i = 1'($urandom_range(1));
      2:       m_axis_tready_i = ~m_axis_tready_i;
      default: m_axis_tready_i = 1'b1;
    endcase
    #4;
    if (a_axis_tvalid_i && a_axis_tready_o) a_q.delete(0);
    if (b_axis_tvalid_i && b_axis_tready_o) b_q.delete(0);
    if (m_axis_tvalid_o && m_axis_tready_i) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      out_q.push_back({m_axis_tlast_o, m_axis_tuser_o, m_axis_tkeep_o, m_axis_tdata_o});
    end
`ifdef MOLD_AB_GAP_DETECT_EN
    if (gap_v_o) begin
      gap_seen++;
      gap_last = gap_len_o;
    end
`endif
    cyc++;
    @(posedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((a_q.size() > 0 || b_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      check_eq("drain_timeout", 128'(a_q.size() + b_q.size()), 128'd0);
      a_q.delete();
      b_q.delete();
    end
    repeat (3) step();
  endtask

  task automatic compare(input string tag);
    #1;
    check_eq({tag, "_nbeats"}, 128'(out_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_beat%0d", tag, i), 128'(out_q[i]), 128'(exp_q[i]));
    check_eq({tag, "_exp_seq"}, 128'(exp_seq_o), 128'(m_exp_seq));
    check_eq({tag, "_drop_cnt"}, 128'(drop_cnt_o), 128'(m_drop));
`ifdef MOLD_AB_GAP_DETECT_EN
    check_eq({tag, "_gap_pulses"}, 128'(gap_seen), 128'(exp_gap_n));
    if (exp_gap_n > 0) check_eq({tag, "_gap_len"}, 128'(gap_last), 128'(exp_gap_len));
`endif
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic model_reset();
    a_q.delete(); b_q.delete(); out_q.delete(); exp_q.delete();
    m_exp_seq = 64'd0;
    m_exp_vld = 1'b0;
    m_drop    = 0;
    gap_seen  = 0;
    exp_gap_n = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m_tvalid"}, 128'(m_axis_tvalid_o), 128'd0);
    check_eq({tag, "_a_tready"}, 128'(a_axis_tready_o), 128'd0);
    check_eq({tag, "_b_tready"}, 128'(b_axis_tready_o), 128'd0);
    check_eq({tag, "_exp_seq"},  128'(exp_seq_o), 128'd0);
    check_eq({tag, "_drop_cnt"}, 128'(drop_cnt_o), 128'd0);
`ifdef MOLD_AB_GAP_DETECT_EN
    check_eq({tag, "_gap_v"},   128'(gap_v_o), 128'd0);
    check_eq({tag, "_gap_len"}, 128'(gap_len_o), 128'd0);
`endif
  endtask

  task automatic release_reset(input string tag);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq({tag, "_a_tready_up"}, 128'(a_axis_tready_o), 128'd1);
    check_eq({tag, "_b_tready_up"}, 128'(b_axis_tready_o), 128'd1);
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          start_cyc;
    int          n;
    logic [63:0] seq;
    logic [15:0] cnt;
    int          len;

    reset = 1'b1;
    a_axis_tvalid_i = 1'b0; a_axis_tkeep_i = '0; a_axis_tdata_i = '0;
    a_axis_tlast_i  = 1'b0; a_axis_tuser_i = 1'b0;
    b_axis_tvalid_i = 1'b0; b_axis_tkeep_i = '0; b_axis_tdata_i = '0;
    b_axis_tlast_i  = 1'b0; b_axis_tuser_i = 1'b0;
    m_axis_tready_i = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("init_rst");
    release_reset("init_rst");

    // First packet after reset, with latency from beat0 in to beat0 out.
    gaps_en = 1'b0; rdy_mode = 1;
    start_cyc = cyc; first_out_cyc = -1;
    make_pkt(1'b0, 64'd5, 16'd1, 5);
    drain(200);
    check_eq("t1_latency", 128'(first_out_cyc - start_cyc), 128'd3);
    compare("t1");

    // Identical packets on both feeds in the same cycle.
    make_pkt(1'b0, 64'd6, 16'd2, 4);
    make_pkt(1'b1, 64'd6, 16'd2, 4);
    drain(200);
    compare("t2_dup");

    // Stale packet.
    make_pkt(1'b0, 64'd3, 16'd7, 4);
    drain(200);
    compare("t3_stale");

    // Forward ahead of expected (gap of 4).
    make_pkt(1'b1, 64'd12, 16'd1, 3);
    drain(200);
    compare("t4_gap");

    // Downstream ready toggling every cycle.
    rdy_mode = 2;
    make_pkt(1'b0, 64'd13, 16'd3, 9);
    drain(400);
    compare("t5_toggle");

    // Early tlast in beat1 on A and beat0 on B.
    rdy_mode = 1;
    make_pkt(1'b0, 64'd16, 16'd1, 2);
    make_pkt(1'b1, 64'd16, 16'd1, 1);
    drain(200);
    compare("t6_short");

    // Count of FFFF leaves exp_seq at seq.
    make_pkt(1'b1, 64'd16, 16'hFFFF, 3);
    drain(200);
    compare("t7_cntff");

    // Random single packets on random feeds with random gaps and backpressure.
    gaps_en = 1'b1; rdy_mode = 0;
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(3))
        0:       seq = m_exp_seq - 64'($urandom_range(1, 5));
        1:       seq = m_exp_seq;
        2:       seq = m_exp_seq + 64'($urandom_range(1, 9));
        default: seq = {$urandom, $urandom};
      endcase
      cnt = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom_range(20));
      len = ($urandom_range(5) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(3, 8));
      make_pkt(1'($urandom_range(1)), seq, cnt, len);
      drain(2000);
      compare($sformatf("rnd%0d", r));
    end

    // Reset while a forwarded packet is streaming.
    gaps_en = 1'b0; rdy_mode = 1;
    make_pkt(1'b1, m_exp_seq + 64'd100, 16'd4, 12);
    n = 0;
    while (out_q.size() < 4 && n < 50) begin
      step();
      n++;
    end
    check_eq("t8_reached_stream", 128'(out_q.size() >= 4), 128'd1);
    #2;
    reset = 1'b1;
    a_axis_tvalid_i = 1'b0;
    b_axis_tvalid_i = 1'b0;
    #1;
    check_reset_outputs("t8_midrst");
    release_reset("t8_midrst");
    make_pkt(1'b0, 64'd2, 16'd1, 4);
    drain(200);
    compare("t8_post_rst");

    // Drop counter saturation with back-to-back single-beat packets on both feeds.
    for (int r = 0; r < 32800; r++) begin
      make_pkt(1'b0, 64'd0, 16'd0, 1);
      make_pkt(1'b1, 64'd0, 16'd0, 1);
    end
    drain(40000);
    compare("t9_sat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
